// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- control unit of the 1-bit CPU.
// Fetches 12-bit instructions {opcode[3:0], operand[7:0]} from a program ROM
// with a 1-cycle synchronous read, decodes them, and drives the ALU
// (alu_op_o / wr_cr_o), the data RAM (data_addr_o / data_rd_en_o / mem_wr_o)
// and the program counter (jumps, skip-if-zero).
// Ports:
//   clk_i, rst_ni     clock (rising edge), async active-low reset
//   run_i             start pulse, honoured in IDLE and HALTED only
//   prog_addr_o/en_o  program ROM address (= PC) and read strobe
//   prog_data_i       instruction word, valid the cycle after prog_en_o
//   data_addr_o       data RAM address (operand field)
//   data_rd_en_o      data read strobe (ALU data_in valid next cycle)
//   mem_wr_o          data write strobe
//   alu_op_o, wr_cr_o ALU opcode and current-result write enable
//   zero_flag_i       ALU zero flag (combinational on ALU data_out)
//   busy_o, halted_o  status
module cpu_sequencer #(
  parameter int PC_WIDTH   = 8,
  parameter int OPND_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  output logic [PC_WIDTH-1:0]   prog_addr_o,
  output logic                  prog_en_o,
  input  logic [11:0]           prog_data_i,
  output logic [OPND_WIDTH-1:0] data_addr_o,
  output logic                  data_rd_en_o,
  output logic                  mem_wr_o,
  output logic [3:0]            alu_op_o,
  output logic                  wr_cr_o,
  input  logic                  zero_flag_i,
  output logic                  busy_o,
  output logic                  halted_o
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_STN  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_SKZ  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED} state_t;

  state_t                state_q;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [3:0]            opc_q;        // opcode of the instruction in flight
  logic [OPND_WIDTH-1:0] data_addr_q;
  logic [3:0]            alu_op_q, alu_op_d;
  logic                  wr_cr_q, mem_wr_q;

  logic [3:0]            opc_in;
  logic [OPND_WIDTH-1:0] opnd_in;
  logic                  is_alu_in, is_st_in;

  assign opc_in    = prog_data_i[11:8];
  assign opnd_in   = OPND_WIDTH'(prog_data_i[7:0]);
  assign is_alu_in = (opc_in >= OP_LD) && (opc_in <= OP_NOT);
  assign is_st_in  = (opc_in == OP_ST) || (opc_in == OP_STN);

  always_comb begin
    alu_op_d = OP_NOP;
    if (opc_in >= OP_LD && opc_in <= OP_STN) alu_op_d = opc_in;
    else if (opc_in == OP_SKZ)               alu_op_d = OP_ST; // exposes current result on zero_flag
  end

  // EXEC-cycle PC advance; wraps modulo 2^PC_WIDTH.
  always_comb begin
    pc_d = pc_q + PC_WIDTH'(1);
    if (opc_q == OP_SKZ && zero_flag_i) pc_d = pc_q + PC_WIDTH'(2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      opc_q       <= OP_NOP;
      data_addr_q <= '0;
      alu_op_q    <= OP_NOP;
      wr_cr_q     <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      // ALU/RAM write strobes live for exactly the EXEC cycle.
      wr_cr_q  <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE:  if (run_i) state_q <= S_FETCH;
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          opc_q       <= opc_in;
          data_addr_q <= opnd_in;
          if (opc_in == OP_JMP) begin
            pc_q    <= PC_WIDTH'(opnd_in);
            state_q <= S_FETCH;
          end else if (opc_in == OP_HALT) begin
            state_q <= S_HALTED;
          end else begin
            alu_op_q <= alu_op_d;
            wr_cr_q  <= is_alu_in;
            mem_wr_q <= is_st_in;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc_q    <= pc_d;
          state_q <= S_FETCH;
        end
        S_HALTED: if (run_i) begin
          pc_q    <= '0;
          state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The instruction only arrives during DECODE, so the data read strobe and
  // its address must be decoded straight from prog_data_i in that cycle.
  assign data_rd_en_o = (state_q == S_DECODE) && is_alu_in;
  assign data_addr_o  = (state_q == S_DECODE) ? opnd_in : data_addr_q;

  assign prog_addr_o = pc_q;
  assign prog_en_o   = (state_q == S_FETCH);
  assign alu_op_o    = alu_op_q;
  assign wr_cr_o     = wr_cr_q;
  assign mem_wr_o    = mem_wr_q;
  assign busy_o      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted_o    = (state_q == S_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] prog_addr;
  logic       prog_en;
  logic [11:0] prog_data = 12'h000;
  logic [7:0] data_addr;
  logic       data_rd_en, mem_wr, wr_cr, busy, halted;
  logic [3:0] alu_op;
  logic       zf = 1'b0;

  cpu_sequencer #(.PC_WIDTH(8), .OPND_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run),
    .prog_addr_o(prog_addr), .prog_en_o(prog_en), .prog_data_i(prog_data),
    .data_addr_o(data_addr), .data_rd_en_o(data_rd_en), .mem_wr_o(mem_wr),
    .alu_op_o(alu_op), .wr_cr_o(wr_cr), .zero_flag_i(zf),
    .busy_o(busy), .halted_o(halted)
  );

  always #5 clk = ~clk;

  // Program ROM with 1-cycle synchronous read.
  logic [11:0] rom [256];
  always @(posedge clk) if (prog_en) prog_data <= rom[prog_addr];

  // Scoreboard entries: 0 fetch(addr), 1 data read(addr), 2 wr_cr(op), 3 mem_wr(addr,op)
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [3:0] op;
  } ev_t;
  ev_t exp_q[$];

  int errors = 0;
  int checks = 0;

  function automatic ev_t mk(int kind, logic [7:0] addr, logic [3:0] op);
    ev_t e;
    e.kind = kind; e.addr = addr; e.op = op;
    return e;
  endfunction

  task automatic push(int kind, logic [7:0] addr, logic [3:0] op);
    exp_q.push_back(mk(kind, addr, op));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic observe(int kind, logic [7:0] addr, logic [3:0] op);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d addr %0h op %0h with nothing expected at %0t",
               kind, addr, op, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != 2 && e.addr !== addr) || (kind >= 2 && e.op !== op)) begin
        errors++;
        $display("FAIL event: got kind %0d addr %0h op %0h, expected kind %0d addr %0h op %0h at %0t",
                 kind, addr, op, e.kind, e.addr, e.op, $time);
      end
    end
  endtask

  // Monitor: samples on the falling edge, independent of stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prog_en)    observe(0, prog_addr, 4'h0);
      if (data_rd_en) observe(1, data_addr, 4'h0);
      if (wr_cr)      observe(2, 8'h00, alu_op);
      if (mem_wr)     observe(3, data_addr, alu_op);
      if (wr_cr && mem_wr) begin
        checks++; errors++;
        $display("FAIL wr_cr_and_mem_wr: both high at %0t", $time);
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic do_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_halted(string name);
    int n = 0;
    while (!halted && n < 300) begin @(negedge clk); n++; end
    chk({name, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    clear_rom();
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_prog_en", {31'd0, prog_en}, 0);
    chk("rst_busy_halted", {30'd0, busy, halted}, 0);
    chk("rst_strobes", {29'd0, data_rd_en, wr_cr, mem_wr}, 0);
    chk("rst_addrs_op", {12'd0, prog_addr, data_addr, alu_op}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);

    // T1: LD 0x05, cycle-accurate
    rom[0] = 12'h105; rom[1] = 12'hB00;
    push(0, 8'h00, 0); push(1, 8'h05, 0); push(2, 0, 4'h1); push(0, 8'h01, 0);
    do_run();
    chk("t1_c1_fetch", {23'd0, prog_en, prog_addr}, {23'd0, 1'b1, 8'h00});
    @(negedge clk);
    chk("t1_c2_rd", {23'd0, data_rd_en, data_addr}, {23'd0, 1'b1, 8'h05});
    @(negedge clk);
    chk("t1_c3_exec", {26'd0, wr_cr, mem_wr, alu_op}, {26'd0, 1'b1, 1'b0, 4'h1});
    @(negedge clk);
    chk("t1_c4_fetch", {23'd0, prog_en, prog_addr}, {23'd0, 1'b1, 8'h01});
    wait_halted("t1");
    @(negedge clk);
    chk("t1_halt_status", {26'd0, busy, halted, prog_en, data_rd_en, wr_cr, mem_wr},
        {26'd0, 6'b010000});

    // T2: LD 01, AND 02, ST 03; a run pulse while busy must be ignored
    clear_rom();
    rom[0] = 12'h101; rom[1] = 12'h302; rom[2] = 12'h703; rom[3] = 12'hB00;
    push(0, 8'h00, 0); push(1, 8'h01, 0); push(2, 0, 4'h1);
    push(0, 8'h01, 0); push(1, 8'h02, 0); push(2, 0, 4'h3);
    push(0, 8'h02, 0); push(3, 8'h03, 4'h7);
    push(0, 8'h03, 0);
    do_run();
    repeat (2) @(negedge clk);
    run = 1'b1; @(negedge clk); run = 1'b0;
    wait_halted("t2");

    // T3: JMP 0x10 -> JMP 0x40 -> HALT
    clear_rom();
    rom[8'h00] = 12'h910; rom[8'h10] = 12'h940; rom[8'h40] = 12'hB00;
    push(0, 8'h00, 0); push(0, 8'h10, 0); push(0, 8'h40, 0);
    do_run();
    wait_halted("t3");

    // T4: SKZ at 0x20 with zero_flag 1 then 0
    clear_rom();
    rom[8'h00] = 12'h920; rom[8'h20] = 12'hA00; rom[8'h21] = 12'hB00; rom[8'h22] = 12'hB00;
    zf = 1'b1;
    push(0, 8'h00, 0); push(0, 8'h20, 0); push(0, 8'h22, 0);
    do_run();
    wait_halted("t4a");
    zf = 1'b0;
    push(0, 8'h00, 0); push(0, 8'h20, 0); push(0, 8'h21, 0);
    do_run();
    wait_halted("t4b");

    // T5a: NOP at 0xFF wraps to 0x00 (ROM[0] becomes HALT once 0xFF is fetched)
    clear_rom();
    rom[8'h00] = 12'h9FF; rom[8'hFF] = 12'h000;
    push(0, 8'h00, 0); push(0, 8'hFF, 0); push(0, 8'h00, 0);
    do_run();
    begin
      int n = 0;
      while (!(prog_en && prog_addr == 8'hFF) && n < 50) begin @(negedge clk); n++; end
      chk("t5a_reach_ff", {31'd0, prog_en}, 1);
    end
    rom[8'h00] = 12'hB00;
    wait_halted("t5a");
    // T5b: SKZ at 0xFF with zero_flag 1 -> 0x01
    clear_rom();
    rom[8'h00] = 12'h9FF; rom[8'hFF] = 12'hA00; rom[8'h01] = 12'hB00;
    zf = 1'b1;
    push(0, 8'h00, 0); push(0, 8'hFF, 0); push(0, 8'h01, 0);
    do_run();
    wait_halted("t5b");
    zf = 1'b0;

    // T6: reset during EXEC of ST 0x33
    clear_rom();
    rom[8'h00] = 12'h733; rom[8'h01] = 12'hB00;
    push(0, 8'h00, 0); push(3, 8'h33, 4'h7);
    do_run();
    begin
      int n = 0;
      while (!mem_wr && n < 20) begin @(negedge clk); n++; end
      chk("t6_mem_wr_seen", {31'd0, mem_wr}, 1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t6_abort_strobes", {28'd0, mem_wr, wr_cr, prog_en, data_rd_en}, 0);
    chk("t6_abort_status", {26'd0, busy, halted, alu_op}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle", {30'd0, busy, halted}, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
